uart_rx_deframer: RTL
=====================

// Module: uart_rx_deframer
// PURPOSE
//   Serial UART receiver: the stage directly downstream of the UART transmitter; consumes its 'tx' line.
//   Frame: start(0), 8 data bits LSB first, optional parity bit, stop(1).
//   Synchronises the line, recovers bits by mid-bit sampling, and presents each byte with a 1-cycle valid pulse.
//   Flags parity and framing errors alongside each byte.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per serial bit; legal range 4..65535
//   DATA_BITS     8   data bits per frame; fixed at 8 in this release
// PORTS
//   clk          in   1  system clock; all logic on posedge
//   rst          in   1  synchronous, active-high reset
//   rx           in   1  serial line, idle high; asynchronous to clk
//   parity_en    in   1  1 = frame carries a parity bit
//   even_parity  in   1  1 = even parity, 0 = odd; ignored when parity_en=0
//   data_out     out  8  last received byte; held until next rx_valid
//   rx_valid     out  1  1-cycle pulse: data_out/parity_err/frame_err are new
//   parity_err   out  1  parity mismatch on last frame; 0 when parity disabled
//   frame_err    out  1  stop bit sampled as 0 on last frame
//   busy         out  1  1 while a frame is in progress (state != IDLE)
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, counters=0, sync flops=1, data_out=8'h00.
//     Reset values: rx_valid=0, parity_err=0, frame_err=0, busy=0.
//     Reset mid-frame aborts the frame with no rx_valid.
//   Sync: rx passes 2 flops -> rx_s; 2-cycle latency; only rx_s is used internally.
//   Counters: clk_cnt (log2 CLKS_PER_BIT bits, saturates never, cleared on every state change); bit_idx 0..7.
//   IDLE: busy=0. rx_s==0 -> START, clk_cnt=0.
//   START: at clk_cnt==CLKS_PER_BIT/2-1 (mid start bit):
//     rx_s==0 -> DATA, clk_cnt=0, bit_idx=0.
//     Latch parity_en/even_parity here; they are constant for the rest of the frame.
//     rx_s==1 -> glitch; back to IDLE, no rx_valid.
//   DATA: at clk_cnt==CLKS_PER_BIT-1: shreg[bit_idx]=rx_s, clk_cnt=0.
//     After bit_idx==7 -> PARITY if latched parity_en, else STOP.
//   PARITY: at clk_cnt==CLKS_PER_BIT-1: perr = rx_s ^ expected.
//     expected = ^shreg for even parity; expected = ~^shreg for odd parity. Then -> STOP.
//   STOP: at clk_cnt==CLKS_PER_BIT-1 -> IDLE.
//     Next cycle: rx_valid=1, data_out=shreg, frame_err=~rx_s, parity_err=perr (0 if parity off).
//   Sample points therefore fall CLKS_PER_BIT/2 cycles into each bit after the start edge.
//   Byte delivery: rx_valid is asserted even when errors are flagged; consumers qualify with the flags.
//     No backpressure: consumers must take the byte in the rx_valid cycle.
//   Error flags hold until the next rx_valid.
//   Held-low line (break): repeated frames, data 0x00, frame_err=1 each.
//   Back-to-back frames: a start bit immediately after the stop sample is detected from IDLE; no gap required.
//   busy=1 in START/DATA/PARITY/STOP.
// TESTING  (CLKS_PER_BIT=4; each bit driven for 4 clk)
//   1. parity_en=0, send 0xA5 -> one rx_valid pulse, data_out=8'hA5, parity_err=0, frame_err=0.
//   2. parity_en=1, even_parity=1:
//      0x3C with parity bit 0 -> data_out=8'h3C, parity_err=0.
//      Same byte with parity bit 1 -> parity_err=1.
//   3. parity_en=1, even_parity=0, send 0x01 with parity bit 0 -> parity_err=0, data_out=8'h01.
//   4. Stop bit driven 0 on 0x55 -> rx_valid=1, data_out=8'h55, frame_err=1.
//      Following good frame 0x0F -> frame_err=0.
//   5. rx low for 1 clk only -> no rx_valid; busy returns to 0 within 4 clk.
//   6. rst=1 during DATA of 0xFF, then send 0x81 -> no pulse for the aborted frame.
//      0x81 is received cleanly; 500 random back-to-back frames match a scoreboard model.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART receiver: two-flop line synchroniser, mid-bit sampling, optional parity,
// and a registered one-cycle rx_valid strobe with parity/framing flags.
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 even_parity,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 pen_q, pen_d;
    logic                 even_q, even_d;
    logic                 perr_q, perr_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d      = state_q;
        sync_d       = {sync_q[0], rx};
        clk_cnt_d    = clk_cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        pen_d        = pen_q;
        even_d       = even_q;
        perr_d       = perr_q;
        data_out_d   = data_out_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    if (!rx_s) begin
                        // Frame format is frozen here so mid-frame input changes are harmless.
                        state_d   = DATA;
                        bit_idx_d = '0;
                        pen_d     = parity_en;
                        even_d    = even_parity;
                        perr_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d          = '0;
                    shreg_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d = '0;
                    perr_d    = rx_s ^ (even_q ? ^shreg_q : ~^shreg_q);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d    = '0;
                    state_d      = IDLE;
                    rx_valid_d   = 1'b1;
                    data_out_d   = shreg_q;
                    frame_err_d  = ~rx_s;
                    parity_err_d = pen_q & perr_q;
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            pen_q        <= 1'b0;
            even_q       <= 1'b0;
            perr_q       <= 1'b0;
            data_out_q   <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            pen_q        <= pen_d;
            even_q       <= even_d;
            perr_q       <= perr_d;
            data_out_q   <= data_out_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule
